// File: rtl/cpu_pkg.sv
// Shared CPU instruction-format constants and field helpers, used by the decode
// stage and by ALU control.
package cpu_pkg;

    localparam int CPU_INSTR_W    = 16;
    localparam int CPU_OP_W       = 4;
    localparam int CPU_A_W        = 4;
    localparam int CPU_B_W        = 4;
    localparam int CPU_IMM_W      = CPU_INSTR_W - CPU_OP_W - CPU_A_W - CPU_B_W;
    localparam int CPU_FIFO_DEPTH = 4;

    typedef enum logic [CPU_OP_W-1:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_XOR = 4'h4,
        OP_SHL = 4'h5,
        OP_SHR = 4'h6,
        OP_LDI = 4'h7,
        OP_NOP = 4'hF
    } cpu_opcode_e;

    // Field layout, MSB first: opcode | A | B | imm.
    function automatic logic [CPU_OP_W-1:0] get_opcode(input logic [CPU_INSTR_W-1:0] w);
        return w[CPU_INSTR_W-1 -: CPU_OP_W];
    endfunction

    function automatic logic [CPU_A_W-1:0] get_a(input logic [CPU_INSTR_W-1:0] w);
        return w[CPU_INSTR_W-CPU_OP_W-1 -: CPU_A_W];
    endfunction

    function automatic logic [CPU_B_W-1:0] get_b(input logic [CPU_INSTR_W-1:0] w);
        return w[CPU_INSTR_W-CPU_OP_W-CPU_A_W-1 -: CPU_B_W];
    endfunction

    function automatic logic [CPU_IMM_W-1:0] get_imm(input logic [CPU_INSTR_W-1:0] w);
        return w[CPU_IMM_W-1:0];
    endfunction

endpackage

// File: rtl/cpu_instr_fifo.sv
// Register-based instruction FIFO with push/pop/flush and an explicit occupancy
// count. The head word is presented combinationally so the decode stage can load it.
module cpu_instr_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && !flush && (wr_ptr_q == PTR_W'(gi)))
                    mem[gi] <= wdata;
            end
        end
    endgenerate

    assign rdata = mem[rd_ptr_q];
    assign cnt   = cnt_q;
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/cpu_fetch_decode.sv
// Buffered instruction decode stage: FIFO in front of a registered output word
// that is sliced into opcode / A / B / imm fields.
module cpu_fetch_decode
    import cpu_pkg::*;
#(
    parameter int INSTR_W = CPU_INSTR_W,
    parameter int OP_W    = CPU_OP_W,
    parameter int A_W     = CPU_A_W,
    parameter int B_W     = CPU_B_W,
    parameter int IMM_W   = INSTR_W - OP_W - A_W - B_W,
    parameter int DEPTH   = CPU_FIFO_DEPTH,
    parameter int CNT_W   = $clog2(DEPTH + 2)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    opcode,
    output logic [A_W-1:0]     input_A,
    output logic [B_W-1:0]     input_B,
    output logic [IMM_W-1:0]   imm,
    output logic [CNT_W-1:0]   count
);

    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    logic               fifo_push, fifo_pop;
    logic [INSTR_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               fifo_full, fifo_empty;
    logic               in_fire, out_fire, load;

    cpu_instr_fifo #(
        .W     (INSTR_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_instr),
        .rdata (fifo_rdata),
        .cnt   (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Readiness depends only on registered state, never on out_ready.
    assign in_ready = !fifo_full && !flush;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;
    assign load     = !out_valid_q || out_fire;

    always_comb begin
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            if (!fifo_empty) begin
                // Queued work goes first; a new word joins the tail.
                fifo_pop    = 1'b1;
                fifo_push   = in_fire;
                instr_d     = fifo_rdata;
                out_valid_d = 1'b1;
            end else if (in_fire) begin
                instr_d     = in_instr;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            fifo_push = in_fire;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            instr_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign count     = fifo_cnt + CNT_W'(out_valid_q);
    assign opcode    = instr_q[INSTR_W-1 -: OP_W];
    assign input_A   = instr_q[INSTR_W-OP_W-1 -: A_W];
    assign input_B   = instr_q[INSTR_W-OP_W-A_W-1 -: B_W];
    assign imm       = instr_q[IMM_W-1:0];

endmodule

// File: tb/tb_cpu_fetch_decode.sv
// Bench for cpu_fetch_decode: a queue model of the whole stage checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cpu_fetch_decode;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 2);

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [15:0]      in_instr;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       opcode, input_A, input_B, imm;
    logic [CNT_W-1:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_fetch_decode dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opcode    (opcode),
        .input_A   (input_A),
        .input_B   (input_B),
        .imm       (imm),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every word held by the stage (output register first, then FIFO) in order.
    logic [15:0] m_q[$];
    logic [15:0] m_last;
    bit          m_fi, m_fo;

    function automatic bit exp_in_ready();
        return !flush && (m_q.size() != DEPTH + 1);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_last = '0;
        end else if (flush) begin
            m_q.delete();
        end else begin
            m_fi = in_valid && (m_q.size() != DEPTH + 1);
            m_fo = (m_q.size() > 0) && out_ready;
            if (m_fo) void'(m_q.pop_front());
            if (m_fi) m_q.push_back(in_instr);
            if (m_q.size() > 0) m_last = m_q[0];
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
            chk("count", 32'(count), 32'(m_q.size()));
            chk("in_ready", 32'(in_ready), 32'(exp_in_ready()));
            chk("fields", 32'({opcode, input_A, input_B, imm}), 32'(m_last));
        end
    end

    // Upstream contract: a stalled word stays presented and unchanged.
    assert property (@(posedge clk) disable iff (!rst || flush)
        (in_valid && !in_ready) |=> (in_valid && $stable(in_instr)));

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] rcv[$];
    bit          will_fire;
    int          ready_pct;

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        repeat (3) cycle();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_fields", 32'({opcode, input_A, input_B, imm}), 32'd0);
        rst = 1'b1;
        cycle();

        // Bypass into an empty stage: fields visible right after the accepting edge.
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 16'hA53C;
        cycle();
        chk("byp_opcode", 32'(opcode), 32'hA);
        chk("byp_A", 32'(input_A), 32'h5);
        chk("byp_B", 32'(input_B), 32'h3);
        chk("byp_imm", 32'(imm), 32'hC);
        chk("byp_valid", 32'(out_valid), 32'd1);
        chk("byp_count", 32'(count), 32'd1);
        in_valid = 1'b0;
        cycle();

        // Backpressure fill, then full-with-pop refuses input.
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            in_instr = 16'(k) << 12;
            cycle();
        end
        in_instr = 16'h6000;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(count), 32'd5);
        chk("full_opcode", 32'(opcode), 32'd1);
        cycle();
        chk("hold_count", 32'(count), 32'd5);
        chk("hold_opcode", 32'(opcode), 32'd1);
        out_ready = 1'b1;
        #1;
        chk("fullpop_in_ready", 32'(in_ready), 32'd0);
        cycle();
        chk("fullpop_count", 32'(count), 32'd4);
        chk("fullpop_in_ready_after", 32'(in_ready), 32'd1);
        chk("drain_op2", 32'(opcode), 32'd2);
        cycle();
        chk("drain_op3", 32'(opcode), 32'd3);
        chk("pushpop_count", 32'(count), 32'd4);
        in_valid = 1'b0;
        for (int k = 4; k <= 6; k++) begin
            cycle();
            chk("drain_op", 32'(opcode), 32'(k));
        end
        cycle();
        chk("drained_valid", 32'(out_valid), 32'd0);
        chk("drained_count", 32'(count), 32'd0);

        // Flush with work queued and a word on the input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h8111; cycle();
        in_instr  = 16'h8222; cycle();
        in_instr  = 16'h8333; cycle();
        chk("preflush_count", 32'(count), 32'd3);
        in_instr = 16'h9444;
        flush    = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_fields", 32'({opcode, input_A, input_B, imm}), 32'h8111);
        in_instr  = 16'h7001;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();
        chk("postflush_fields", 32'({opcode, input_A, input_B, imm}), 32'h7001);
        chk("postflush_valid", 32'(out_valid), 32'd1);
        chk("postflush_count", 32'(count), 32'd1);
        in_valid = 1'b0;
        cycle();

        // Pointer wrap with one or two words resident.
        rcv.delete();
        for (int i = 0; i < 14; i++) begin
            in_valid  = 1'b1;
            in_instr  = 16'hB000 + 16'(i);
            out_ready = (i >= 2);
            if (out_valid && out_ready) rcv.push_back({opcode, input_A, input_B, imm});
            cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid && out_ready) rcv.push_back({opcode, input_A, input_B, imm});
            cycle();
        end
        chk("wrap_received", 32'(rcv.size()), 32'd14);
        for (int i = 0; i < 14 && i < rcv.size(); i++)
            chk("wrap_order", 32'(rcv[i]), 32'(16'hB000 + 16'(i)));

        // Reset asserted with three words in flight clears everything at once.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'hC001; cycle();
        in_instr  = 16'hC002; cycle();
        in_instr  = 16'hC003; cycle();
        in_valid  = 1'b0;
        rst       = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_fields", 32'({opcode, input_A, input_B, imm}), 32'd0);
        cycle();
        rst = 1'b1;
        cycle();

        // Randomized traffic; stalled words are held until accepted.
        will_fire = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            ready_pct = ((n / 200) % 2 == 1) ? 30 : 80;
            if (!(in_valid && !will_fire)) begin
                in_valid = ($urandom_range(0, 9) < 8);
                in_instr = 16'($urandom);
            end
            out_ready = ($urandom_range(0, 99) < ready_pct);
            flush     = ($urandom_range(0, 39) == 0);
            #1;
            will_fire = in_valid && in_ready;
            cycle();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
